// File: rtl/eth_switch_pkg.sv
// eth_switch_pkg: mode encoding and counter width shared by the Ethernet stream switch
package eth_switch_pkg;
  typedef enum logic [1:0] {
    MODE_LOOPBACK = 2'b00,
    MODE_ROTATE   = 2'b01,
    MODE_DRAIN    = 2'b10
  } mode_e;
  localparam int CNT_W = 32;
  function automatic mode_e norm_mode(input logic [1:0] m);
    return m[1] ? MODE_DRAIN : mode_e'(m);
  endfunction
endpackage

// File: rtl/eth_sfifo.sv
// eth_sfifo: first-word-fall-through FIFO; pointers clear asynchronously on reset
module eth_sfifo #(
  parameter int W = 8,
  parameter int D = 16
) (
  input  logic         ap_clk,
  input  logic         areset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(D);
  localparam logic [AW:0] ONE = 1;
  logic [W-1:0] mem [D];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge ap_clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge ap_clk or posedge areset)
    if (areset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + ONE;
      if (do_pop) rp <= rp + ONE;
    end
endmodule

// File: rtl/eth_stream_switch.sv
// eth_stream_switch: per-channel FIFOs routed loopback/rotate/drain, with mode
// changes applied only once every input is between packets and all FIFOs are empty
module eth_stream_switch
  import eth_switch_pkg::*;
#(
  parameter int C_NUM_CH      = 2,
  parameter int C_TDATA_WIDTH = 512,
  parameter int C_FIFO_DEPTH  = 16
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic [C_NUM_CH-1:0]             s_tvalid,
  output logic [C_NUM_CH-1:0]             s_tready,
  input  logic [C_NUM_CH-1:0]             s_tlast,
  input  logic [C_NUM_CH*C_TDATA_WIDTH-1:0]   s_tdata,
  input  logic [C_NUM_CH*C_TDATA_WIDTH/8-1:0] s_tkeep,
  output logic [C_NUM_CH-1:0]             m_tvalid,
  input  logic [C_NUM_CH-1:0]             m_tready,
  output logic [C_NUM_CH-1:0]             m_tlast,
  output logic [C_NUM_CH*C_TDATA_WIDTH-1:0]   m_tdata,
  output logic [C_NUM_CH*C_TDATA_WIDTH/8-1:0] m_tkeep,
  input  logic [1:0]                      mode_req,
  output logic [1:0]                      mode_active,
  output logic [C_NUM_CH*CNT_W-1:0]       pkt_count,
  output logic [C_NUM_CH*CNT_W-1:0]       drop_count
);
  localparam int W  = C_TDATA_WIDTH;
  localparam int KW = C_TDATA_WIDTH / 8;
  localparam int FW = W + KW + 1;
  mode_e mode_q, target;
  logic ready_en, rotate, drain, pending, quiet;
  logic [C_NUM_CH-1:0] in_pkt, acc, empty, full, pop;
  logic [FW-1:0] head [C_NUM_CH];
  logic [C_NUM_CH*CNT_W-1:0] pkt_q, drop_q;
  assign target = norm_mode(mode_req);
  assign rotate = mode_q == MODE_ROTATE;
  assign drain = mode_q == MODE_DRAIN;
  assign pending = target != mode_q;
  assign quiet = ~|in_pkt & &empty;
  assign mode_active = mode_q;
  assign pkt_count = pkt_q;
  assign drop_count = drop_q;
  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    localparam int DST = (i + 1) % C_NUM_CH;
    localparam int SRC = (i + C_NUM_CH - 1) % C_NUM_CH;
    // idle inputs stall while a mode change waits for the datapath to go quiet
    assign s_tready[i] = ready_en & ~(pending & ~in_pkt[i]) & (drain | ~full[i]);
    assign acc[i] = s_tvalid[i] & s_tready[i];
    assign pop[i] = ~empty[i] & (rotate ? m_tready[DST] : m_tready[i]);
    eth_sfifo #(.W(FW), .D(C_FIFO_DEPTH)) u_fifo (
      .ap_clk,
      .areset,
      .push(acc[i] & ~drain),
      .din ({s_tdata[i*W +: W], s_tkeep[i*KW +: KW], s_tlast[i]}),
      .pop (pop[i]),
      .dout(head[i]),
      .empty(empty[i]),
      .full(full[i])
    );
    assign {m_tdata[i*W +: W], m_tkeep[i*KW +: KW], m_tlast[i]} = rotate ? head[SRC] : head[i];
    assign m_tvalid[i] = ~(rotate ? empty[SRC] : empty[i]);
  end
  always_ff @(posedge ap_clk or posedge areset)
    if (areset) begin
      mode_q <= MODE_LOOPBACK;
      in_pkt <= '0;
      ready_en <= 1'b0;
      pkt_q <= '0;
      drop_q <= '0;
    end else begin
      ready_en <= 1'b1;
      if (pending & quiet) mode_q <= target;
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (acc[i]) in_pkt[i] <= ~s_tlast[i];
        if (m_tvalid[i] & m_tready[i] & m_tlast[i])
          pkt_q[i*CNT_W +: CNT_W] <= pkt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        if (acc[i] & drain & s_tlast[i])
          drop_q[i*CNT_W +: CNT_W] <= drop_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_eth_stream_switch.sv
// tb_eth_stream_switch: directed + randomized traffic against a queue-based routing model
module tb_eth_stream_switch;
  localparam int N = 4, W = 32, KW = 4, D = 16;
  logic ap_clk = 0, areset = 1;
  logic [N-1:0] s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic [N*W-1:0] s_tdata, m_tdata;
  logic [N*KW-1:0] s_tkeep, m_tkeep;
  logic [1:0] mode_req, mode_active;
  logic [N*32-1:0] pkt_count, drop_count;
  int n_tests = 0, n_fail = 0;

  typedef struct {logic [W-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
  beat_t q [N][$];
  logic [31:0] pkt_m [N];
  logic [31:0] drop_m [N];
  logic [N-1:0] inpk_m;
  logic [1:0] mode_m;
  bit en_m;
  int len_q [N][$];
  int cur_len [N], beat_i [N], acc_cnt [N];

  eth_stream_switch #(.C_NUM_CH(N), .C_TDATA_WIDTH(W), .C_FIFO_DEPTH(D)) dut (
    .ap_clk(ap_clk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .mode_req(mode_req), .mode_active(mode_active),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  function automatic int dst_of(input int i, input logic [1:0] m);
    return (m == 2'b01) ? (i + 1) % N : i;
  endfunction

  // reference model: each accepted beat is queued on the output it must leave from
  always @(negedge ap_clk) begin
    logic [1:0] tgt;
    bit pend, quiet;
    beat_t b;
    if (areset) begin
      for (int j = 0; j < N; j++) begin
        q[j].delete();
        pkt_m[j] = 0;
        drop_m[j] = 0;
      end
      inpk_m = '0;
      mode_m = 2'b00;
      en_m = 0;
    end else begin
      tgt = mode_req[1] ? 2'b10 : mode_req;
      pend = tgt != mode_m;
      quiet = inpk_m == '0;
      for (int j = 0; j < N; j++) if (q[j].size() != 0) quiet = 0;
      chk("mode_active", 0, mode_active, mode_m);
      for (int j = 0; j < N; j++) begin
        chk("pkt_count", j, pkt_count[j*32 +: 32], pkt_m[j]);
        chk("drop_count", j, drop_count[j*32 +: 32], drop_m[j]);
        chk("m_tvalid", j, m_tvalid[j], q[j].size() != 0);
        chk("s_tready", j, s_tready[j],
            en_m && !(pend && !inpk_m[j]) && (mode_m == 2'b10 || q[dst_of(j, mode_m)].size() < D));
      end
      for (int j = 0; j < N; j++)
        if (m_tvalid[j] && m_tready[j] && q[j].size() != 0) begin
          b = q[j].pop_front();
          chk("m_tdata", j, m_tdata[j*W +: W], b.d);
          chk("m_tkeep", j, m_tkeep[j*KW +: KW], b.k);
          chk("m_tlast", j, m_tlast[j], b.l);
          if (b.l) pkt_m[j]++;
        end
      for (int i = 0; i < N; i++)
        if (s_tvalid[i] && s_tready[i]) begin
          inpk_m[i] = !s_tlast[i];
          if (mode_m == 2'b10) begin
            if (s_tlast[i]) drop_m[i]++;
          end else
            q[dst_of(i, mode_m)].push_back('{s_tdata[i*W +: W], s_tkeep[i*KW +: KW], s_tlast[i]});
        end
      if (pend && quiet) mode_m = tgt;
      en_m = 1;
    end
  end

  task automatic run(input int cycles, input int gap, input int rdy);
    logic [N-1:0] a;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++)
        if (!s_tvalid[i] && (cur_len[i] > 0 || len_q[i].size() > 0) && $urandom_range(99) >= gap) begin
          if (cur_len[i] == 0) cur_len[i] = len_q[i].pop_front();
          s_tvalid[i] = 1;
          s_tdata[i*W +: W] = $urandom;
          s_tkeep[i*KW +: KW] = ($urandom_range(7) == 0) ? '0 : KW'($urandom);
          s_tlast[i] = beat_i[i] == cur_len[i] - 1;
        end
      if (rdy >= 0) for (int j = 0; j < N; j++) m_tready[j] = $urandom_range(99) < rdy;
      @(negedge ap_clk);
      a = s_tvalid & s_tready;
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < N; i++)
        if (a[i]) begin
          acc_cnt[i]++;
          s_tvalid[i] = 0;
          beat_i[i]++;
          if (beat_i[i] == cur_len[i]) begin
            beat_i[i] = 0;
            cur_len[i] = 0;
          end
        end
    end
  endtask

  function automatic int backlog();
    int n = 0;
    for (int i = 0; i < N; i++) n += len_q[i].size() + cur_len[i];
    return n;
  endfunction

  initial begin
    int a0;
    logic [31:0] b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; m_tready = '1; mode_req = 2'b00;
    for (int i = 0; i < N; i++) begin
      cur_len[i] = 0; beat_i[i] = 0; acc_cnt[i] = 0;
    end
    repeat (3) @(posedge ap_clk);
    #1 areset = 0;
    chk("rst_mode", 0, mode_active, 2'b00);
    chk("rst_m_tvalid", 0, m_tvalid, '0);
    chk("rst_s_tready", 0, s_tready, '0);
    chk("rst_pkt", 0, pkt_count, '0);
    chk("rst_drop", 0, drop_count, '0);
    @(posedge ap_clk);
    #1 chk("ready_after_edge", 0, s_tready, 4'hF);
    // loopback: one 4-beat packet on channel 0
    len_q[0].push_back(4);
    run(8, 0, 100);
    chk("lb_pkt", 0, pkt_count[31:0], 1);
    // rotate: one single-beat packet per input
    mode_req = 2'b01;
    run(4, 0, 100);
    chk("rot_mode", 0, mode_active, 2'b01);
    for (int i = 0; i < N; i++) len_q[i].push_back(1);
    run(6, 0, 100);
    for (int j = 0; j < N; j++) chk("rot_pkt", j, pkt_count[j*32 +: 32], (j == 0) ? 2 : 1);
    // backpressure: 20 beats into a 16-deep FIFO with output stalled
    mode_req = 2'b00;
    run(4, 0, 100);
    chk("bp_mode", 0, mode_active, 2'b00);
    m_tready = '0;
    a0 = acc_cnt[0];
    len_q[0].push_back(20);
    run(25, 0, -1);
    chk("bp_acc", 0, acc_cnt[0] - a0, 16);
    chk("bp_ready", 0, s_tready[0], 0);
    m_tready = '1;
    run(30, 0, 100);
    chk("bp_done", 0, acc_cnt[0] - a0, 20);
    chk("bp_pkt", 0, pkt_count[31:0], 3);
    // mode request changes in the middle of a 6-beat packet
    b0 = pkt_m[0];
    len_q[0].push_back(6);
    run(2, 0, 100);
    mode_req = 2'b01;
    run(3, 0, 100);
    chk("ms_hold", 0, mode_active, 2'b00);
    run(10, 0, 100);
    chk("ms_mode", 0, mode_active, 2'b01);
    chk("ms_pkt", 0, pkt_count[31:0], b0 + 1);
    // drain: three 5-beat packets on channel 1 are discarded
    mode_req = 2'b10;
    run(4, 0, 100);
    chk("dr_mode", 0, mode_active, 2'b10);
    a0 = acc_cnt[1];
    b0 = drop_m[1];
    for (int k = 0; k < 3; k++) len_q[1].push_back(5);
    run(15, 0, 100);
    chk("dr_acc", 1, acc_cnt[1] - a0, 15);
    chk("dr_drop", 1, drop_count[63:32], b0 + 3);
    chk("dr_tvalid", 0, m_tvalid, '0);
    mode_req = 2'b11;
    run(3, 0, 100);
    chk("reserved_mode", 0, mode_active, 2'b10);
    // randomized traffic with random mode requests and backpressure
    for (int k = 0; k < 8; k++) begin
      mode_req = 2'($urandom_range(3));
      for (int n = 0; n < int'($urandom_range(4, 1)); n++)
        len_q[$urandom_range(N - 1)].push_back(int'($urandom_range(6, 1)));
      run(40, 30, 70);
    end
    run(150, 0, 100);
    chk("rnd_done", 0, backlog(), 0);
    // counter wrap
    mode_req = 2'b00;
    run(4, 0, 100);
    chk("wrap_mode", 0, mode_active, 2'b00);
    force dut.pkt_q = {pkt_m[3], pkt_m[2], pkt_m[1], 32'hFFFF_FFFF};
    pkt_m[0] = 32'hFFFF_FFFF;
    @(negedge ap_clk);
    #1 release dut.pkt_q;
    chk("wrap_pre", 0, pkt_count[31:0], 32'hFFFF_FFFF);
    @(posedge ap_clk);
    #1 len_q[0].push_back(2);
    run(6, 0, 100);
    chk("wrap", 0, pkt_count[31:0], 0);
    // reset in the middle of a packet
    m_tready = '0;
    len_q[2].push_back(8);
    run(3, 0, -1);
    areset = 1;
    s_tvalid = '0;
    for (int i = 0; i < N; i++) begin
      len_q[i].delete(); cur_len[i] = 0; beat_i[i] = 0;
    end
    #2;
    chk("mid_rst_tvalid", 0, m_tvalid, '0);
    chk("mid_rst_tready", 0, s_tready, '0);
    chk("mid_rst_pkt", 0, pkt_count, '0);
    chk("mid_rst_drop", 0, drop_count, '0);
    @(posedge ap_clk);
    #1 areset = 0;
    m_tready = '1;
    run(10, 0, 100);
    chk("post_rst_tvalid", 0, m_tvalid, '0);
    chk("post_rst_pkt", 0, pkt_count, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_stream_switch.md
ETH_STREAM_SWITCH -- requirements
Module: eth_stream_switch

Interface
REQ-001 SHALL have parameter C_NUM_CH, default 2, number of MAC channels (legal 2..8).
REQ-002 SHALL have parameter C_TDATA_WIDTH, default 512, AXI4-Stream data width in bits (multiple of 8).
REQ-003 SHALL have parameter C_FIFO_DEPTH, default 16, per-channel FIFO depth in beats (power of 2, >=4).
REQ-004 SHALL have port ap_clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port areset  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports s_tvalid/s_tready/s_tlast  in/out/in  C_NUM_CH  per-channel receive handshake and end-of-packet.
REQ-007 SHALL have ports s_tdata, s_tkeep  in  C_NUM_CH*C_TDATA_WIDTH, C_NUM_CH*C_TDATA_WIDTH/8  receive payload, channel i at slice i.
REQ-008 SHALL have ports m_tvalid/m_tready/m_tlast  out/in/out  C_NUM_CH  per-channel transmit handshake and end-of-packet.
REQ-009 SHALL have ports m_tdata, m_tkeep  out  C_NUM_CH*C_TDATA_WIDTH, C_NUM_CH*C_TDATA_WIDTH/8  transmit payload.
REQ-010 SHALL have port mode_req  in  2  requested mode: 00 LOOPBACK, 01 ROTATE, 10 DRAIN, 11 reserved (treated as DRAIN).
REQ-011 SHALL have port mode_active  out  2  mode currently applied.
REQ-012 SHALL have ports pkt_count, drop_count  out  C_NUM_CH*32 each  per-channel transmitted / discarded packet counters.

Function
REQ-013 Each input channel i SHALL own a first-word-fall-through FIFO storing {tdata,tkeep,tlast}.
REQ-014 LOOPBACK: output i SHALL source FIFO i; ROTATE: output (i+1) mod C_NUM_CH SHALL source FIFO i.
REQ-015 s_tready[i] SHALL be high iff FIFO i count < C_FIFO_DEPTH and no switch is pending at a packet boundary; a push at full SHALL not occur even with a same-cycle pop.
REQ-016 A beat accepted at cycle t SHALL be visible on the mapped m_tvalid no earlier than t+1 and no later than t+1 when the FIFO was empty.
REQ-017 m_tvalid SHALL equal FIFO non-empty; m_tdata/m_tkeep/m_tlast SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-018 Per-input state SHALL be IDLE (between packets) or IN_PKT; IDLE->IN_PKT on accepted beat with tlast=0; IN_PKT->IDLE on accepted beat with tlast=1.
REQ-019 DRAIN: s_tready SHALL be 1, input beats SHALL be discarded, outputs SHALL continue emptying already-stored FIFO contents.
REQ-020 When mode_req != mode_active, inputs in IDLE SHALL hold s_tready=0; inputs in IN_PKT SHALL accept until tlast.
REQ-021 mode_active SHALL update to mode_req on the cycle after all inputs are IDLE and all FIFOs are empty; mode_req changing again before then SHALL retarget the pending switch.
REQ-022 pkt_count[j] SHALL increment on m_tvalid&m_tready&m_tlast of output j, wrapping 0xFFFF_FFFF->0.
REQ-023 drop_count[i] SHALL increment on each accepted tlast beat discarded in DRAIN, wrapping 0xFFFF_FFFF->0.
REQ-024 tkeep SHALL pass unmodified; zero tkeep beats SHALL be forwarded, not filtered.

Reset
REQ-025 On areset assertion all FIFOs SHALL empty immediately, asynchronously.
REQ-026 Reset values: m_tvalid=0, s_tready=0, mode_active=00, pkt_count=0, drop_count=0, all inputs IDLE.
REQ-027 s_tready SHALL rise no earlier than the first ap_clk edge after areset deassertion.
REQ-028 Reset mid-packet SHALL discard partial packets; no truncated packet SHALL emerge after reset.

Structure
REQ-029 Package eth_switch_pkg SHALL hold the mode enum (LOOPBACK, ROTATE, DRAIN) and the counter width constant (32).
REQ-030 FIFO SHALL be a sub-module eth_sfifo, parametrised by width and depth, instantiated C_NUM_CH times.

Verification
REQ-031 LOOPBACK, C_NUM_CH=2: 4-beat packet on ch0, m_tready=1 -> identical 4 beats on m ch0 at t+1..t+4, pkt_count[0]=1.
REQ-032 ROTATE, C_NUM_CH=4: one 1-beat packet per input -> in i appears on out (i+1)%4, each pkt_count=1.
REQ-033 Backpressure: m_tready[0]=0, 20 beats offered, depth 16 -> s_tready[0] falls after 16 accepts, no loss after m_tready rises.
REQ-034 Mode switch mid-packet: mode_req 00->01 at beat 2 of 6 -> packet completes on out0, mode_active=01 one cycle after FIFO empty.
REQ-035 DRAIN: three 5-beat packets on ch1 -> s_tready=1 throughout, no m_tvalid, drop_count[1]=3.
REQ-036 Wrap/reset: pkt_count preloaded 0xFFFF_FFFF via force -> next packet yields 0; areset mid-packet -> outputs zero, no partial packet afterward.
